// File: rtl/dp_sram_pkg.sv
// Shared types and constants for the dual-port synchronous SRAM.
// Holds the clear-FSM state encoding and the right-port direction codes.
package dp_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } clr_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dp_sram_if.sv
// Bus bundle for dp_sram_sync: right read/write port, left read-only port and status.
// master drives requests (the user side); slave is the memory itself.
interface dp_sram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              ce_r_n;
  logic              rw_r;
  logic [ADDR_W-1:0] address_r;
  logic [DATA_W-1:0] data_in_r;
  logic [DATA_W-1:0] data_out_r;
  logic              valid_r;

  logic              ce_l_n;
  logic [ADDR_W-1:0] address_l;
  logic [DATA_W-1:0] data_out_l;
  logic              valid_l;

  logic              ready;
  logic              collision;

  modport master (
    output ce_r_n, rw_r, address_r, data_in_r, ce_l_n, address_l,
    input  data_out_r, valid_r, data_out_l, valid_l, ready, collision
  );

  modport slave (
    input  ce_r_n, rw_r, address_r, data_in_r, ce_l_n, address_l,
    output data_out_r, valid_r, data_out_l, valid_l, ready, collision
  );

endinterface

// File: rtl/dp_sram_clr_fsm.sv
// Post-reset clear sequencer: IDLE for one cycle, then zeroes every word once,
// then parks in READY until the next reset.
module dp_sram_clr_fsm
  import dp_sram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops at the last address rather than wrapping, so only one pass runs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        clr_we_o = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o    = (state_q == READY);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dp_sram_sync.sv
// Dual-port synchronous SRAM: right port read/write, left port read-only, 1-cycle reads.
// Define DP_SRAM_BYPASS_EN for write-first forwarding to the left port on a collision.
module dp_sram_sync
  import dp_sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic      clk,
  input logic      rst_n,
  dp_sram_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic              ready;
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;

  logic              rdAccR, wrAccR, rdAccL, hitColl;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] dataOutR_q, dataOutL_q;
  logic              validR_q, validL_q, collision_q;

  dp_sram_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready_o    (ready),
    .clr_we_o   (clrWe),
    .clr_addr_o (clrAddr)
  );

  // Clearing and user writes never overlap because user access is gated by ready.
  always_comb begin
    rdAccR   = ready && !bus.ce_r_n && (bus.rw_r == RW_READ);
    wrAccR   = ready && !bus.ce_r_n && (bus.rw_r == RW_WRITE);
    rdAccL   = ready && !bus.ce_l_n;
    hitColl  = wrAccR && rdAccL && (bus.address_r == bus.address_l);
    memWe    = clrWe || wrAccR;
    memAddr  = clrWe ? clrAddr : bus.address_r;
    memWdata = clrWe ? '0 : bus.data_in_r;
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memWdata;
    end
  end

  // Read registers sample the pre-write array contents, which gives read-first by default.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOutR_q  <= '0;
      dataOutL_q  <= '0;
      validR_q    <= 1'b0;
      validL_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      validR_q    <= rdAccR;
      validL_q    <= rdAccL;
      collision_q <= hitColl;
      if (rdAccR) begin
        dataOutR_q <= mem[bus.address_r];
      end
      if (rdAccL) begin
`ifdef DP_SRAM_BYPASS_EN
        dataOutL_q <= hitColl ? bus.data_in_r : mem[bus.address_l];
`else
        dataOutL_q <= mem[bus.address_l];
`endif
      end
    end
  end

  assign bus.data_out_r = dataOutR_q;
  assign bus.valid_r    = validR_q;
  assign bus.data_out_l = dataOutL_q;
  assign bus.valid_l    = validL_q;
  assign bus.ready      = ready;
  assign bus.collision  = collision_q;

endmodule

// File: tb/tb_dp_sram_sync.sv
// Scoreboard bench for dp_sram_sync: stimulus pushes expected read data and
// collision pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dp_sram_sync;
  import dp_sram_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   totalCnt = 0;
  int   badCnt   = 0;
  int   cycleCnt = 0;
  int   zeros;

  exp_t qR[$];
  exp_t qL[$];
  int   qC[$];
  exp_t eR, eL;
  int   eC;

  logic [DATA_W-1:0] lastR, lastL, collExp;

  dp_sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dp_sram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cr, input logic rw, input logic [ADDR_W-1:0] ar,
                               input logic [DATA_W-1:0] dr, input logic cl,
                               input logic [ADDR_W-1:0] al);
    bus.ce_r_n    = cr;
    bus.rw_r      = rw;
    bus.address_r = ar;
    bus.data_in_r = dr;
    bus.ce_l_n    = cl;
    bus.address_l = al;
  endtask

  task automatic idleBus();
    applyStimulus(1'b1, RW_READ, 4'd0, 8'h00, 1'b1, 4'd0);
  endtask

  task automatic writeR(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    applyStimulus(1'b0, RW_WRITE, a, d, 1'b1, 4'd0);
    stepCycle();
  endtask

  task automatic readBoth(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expR,
                          input logic [DATA_W-1:0] expL);
    applyStimulus(1'b0, RW_READ, a, 8'h00, 1'b0, a);
    qR.push_back('{expR, cycleCnt + 1});
    qL.push_back('{expL, cycleCnt + 1});
    lastR = expR;
    lastL = expL;
    stepCycle();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst data_out_r", 32'(bus.data_out_r), 32'h0);
    checkOutput("rst data_out_l", 32'(bus.data_out_l), 32'h0);
    checkOutput("rst valid_r", 32'(bus.valid_r), 32'h0);
    checkOutput("rst valid_l", 32'(bus.valid_l), 32'h0);
    checkOutput("rst ready", 32'(bus.ready), 32'h0);
    checkOutput("rst collision", 32'(bus.collision), 32'h0);
  endtask

  // Optionally attempts a write to address 2 and a left read late in the clear pass.
  task automatic waitReady(input bit injectWrite, output int nz);
    nz = 0;
    for (int k = 0; k < 64; k++) begin
      if (bus.ready === 1'b1) break;
      if (injectWrite && nz == 15) applyStimulus(1'b0, RW_WRITE, 4'd2, 8'hFF, 1'b0, 4'd5);
      nz++;
      stepCycle();
    end
    idleBus();
    if (bus.ready !== 1'b1) checkOutput("ready timeout", 32'(bus.ready), 32'h1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid_r === 1'b1) begin
        if (qR.size() == 0) begin
          checkOutput("unexpected valid_r", 32'(bus.valid_r), 32'h0);
        end else begin
          eR = qR.pop_front();
          checkOutput("data_out_r", 32'(bus.data_out_r), 32'(eR.data));
          checkOutput("valid_r cycle", 32'(cycleCnt), 32'(eR.cyc));
        end
      end
      if (bus.valid_l === 1'b1) begin
        if (qL.size() == 0) begin
          checkOutput("unexpected valid_l", 32'(bus.valid_l), 32'h0);
        end else begin
          eL = qL.pop_front();
          checkOutput("data_out_l", 32'(bus.data_out_l), 32'(eL.data));
          checkOutput("valid_l cycle", 32'(cycleCnt), 32'(eL.cyc));
        end
      end
      if (bus.collision === 1'b1) begin
        if (qC.size() == 0) begin
          checkOutput("unexpected collision", 32'(bus.collision), 32'h0);
        end else begin
          eC = qC.pop_front();
          checkOutput("collision cycle", 32'(cycleCnt), 32'(eC));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef DP_SRAM_BYPASS_EN
    collExp = 8'h22;
`else
    collExp = 8'h11;
`endif
    lastR = 8'h00;
    lastL = 8'h00;
    idleBus();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    checkResetOutputs();

    // Initial clear with an ignored write to address 2 while not ready.
    rst_n = 1'b1;
    waitReady(1'b1, zeros);
    checkOutput("ready latency", 32'(zeros), 32'd17);
    for (int a = 0; a < DEPTH; a++) readBoth(4'(a), 8'h00, 8'h00);
    idleBus();
    stepCycle();

    // Write then read on both ports.
    writeR(4'd3, 8'hA5);
    readBoth(4'd3, 8'hA5, 8'hA5);
    idleBus();
    stepCycle();

    // Same-address collision, then readback of the new data.
    writeR(4'd7, 8'h11);
    applyStimulus(1'b0, RW_WRITE, 4'd7, 8'h22, 1'b0, 4'd7);
    qL.push_back('{collExp, cycleCnt + 1});
    qC.push_back(cycleCnt + 1);
    stepCycle();
    readBoth(4'd7, 8'h22, 8'h22);
    idleBus();
    stepCycle();

    // Different-address write and left read: no collision, left sees old data.
    applyStimulus(1'b0, RW_WRITE, 4'd8, 8'h5C, 1'b0, 4'd9);
    qL.push_back('{8'h00, cycleCnt + 1});
    lastL = 8'h00;
    stepCycle();
    readBoth(4'd8, 8'h5C, 8'h5C);
    idleBus();
    stepCycle();

    // Disabled left port: outputs must hold.
    applyStimulus(1'b1, RW_READ, 4'd0, 8'h00, 1'b1, 4'd5);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("data_out_l hold", 32'(bus.data_out_l), 32'(lastL));
    checkOutput("valid_l idle", 32'(bus.valid_l), 32'h0);
    checkOutput("data_out_r hold", 32'(bus.data_out_r), 32'(lastR));
    idleBus();

    // Reset with live data, then reset again mid-clear at cnt=9.
    rst_n = 1'b0;
    stepCycle();
    checkResetOutputs();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) stepCycle();
    checkOutput("ready mid-clear", 32'(bus.ready), 32'h0);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    waitReady(1'b0, zeros);
    checkOutput("ready latency after restart", 32'(zeros), 32'd17);
    for (int a = 0; a < DEPTH; a++) readBoth(4'(a), 8'h00, 8'h00);
    idleBus();
    stepCycle();
    stepCycle();

    checkOutput("pending right reads", 32'(qR.size()), 32'h0);
    checkOutput("pending left reads", 32'(qL.size()), 32'h0);
    checkOutput("pending collisions", 32'(qC.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/dp_sram_sync.md
DP_SRAM_SYNC -- requirements
Module: dp_sram_sync

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits of both ports.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ce_r_n  input  1  right-port chip enable, active low.
REQ-006 rw_r  input  1  right-port direction: 1 read, 0 write.
REQ-007 address_r  input  ADDR_W  right-port address.
REQ-008 data_in_r  input  DATA_W  right-port write data.
REQ-009 data_out_r  output  DATA_W  right-port registered read data.
REQ-010 valid_r  output  1  data_out_r holds a new read result this cycle.
REQ-011 ce_l_n  input  1  left-port chip enable, active low; left port is read-only.
REQ-012 address_l  input  ADDR_W  left-port address.
REQ-013 data_out_l  output  DATA_W  left-port registered read data.
REQ-014 valid_l  output  1  data_out_l holds a new read result this cycle.
REQ-015 ready  output  1  high once memory clear completes; ports are ignored while low.
REQ-016 collision  output  1  one-cycle pulse: right write and left read hit the same address in the same cycle.

Function
REQ-017 Reads on either port have a latency of exactly 1 cycle: accepted in cycle N, then data_out_x and valid_x=1 in cycle N+1.
REQ-018 A port is accepted only when ready=1 and ce_x_n=0; a right-port read also requires rw_r=1.
REQ-019 A right-port write (ready=1, ce_r_n=0, rw_r=0) updates memory[address_r] at the clock edge, and valid_r=0 the following cycle.
REQ-020 data_out_x holds its last value when idle; valid_x is 0 in any cycle after a non-accepted cycle.
REQ-021 A right-port read and write to the same address are mutually exclusive by rw_r; back-to-back write then read returns the new data.
REQ-022 On a same-cycle, same-address right write and left read, collision=1 in the next cycle, and data_out_l follows REQ-031.
REQ-023 Clear FSM states are IDLE, CLEAR and READY.
REQ-024 From reset, the FSM goes to CLEAR; CLEAR writes 0 to address cnt and increments cnt from 0.
REQ-025 The transition CLEAR->READY occurs after address DEPTH-1 is written, so clearing takes exactly DEPTH cycles.
REQ-026 READY is terminal until rst_n=0; IDLE is the reset state, lasts exactly one cycle, and then moves to CLEAR.
REQ-027 The address counter is ADDR_W bits wide; terminal detection uses cnt == DEPTH-1, with no wrap into a second pass.
REQ-028 Asserting rst_n=0 mid-CLEAR restarts clearing from address 0.

Reset
REQ-029 While rst_n=0 at a clock edge, the following outputs are 0: data_out_r, data_out_l, valid_r, valid_l, ready and collision; the state is IDLE and cnt=0.
REQ-030 Memory contents are not reset directly; the CLEAR pass zeroes them after reset.

Configuration
REQ-031 With macro DP_SRAM_BYPASS_EN defined, a collision forwards data_in_r to data_out_l (write-first); without it, data_out_l returns the old memory contents (read-first); collision pulses in both builds.

Structure
REQ-032 Package dp_sram_pkg holds the FSM state enum (IDLE, CLEAR, READY) and the constants RW_READ=1 and RW_WRITE=0.
REQ-033 Sub-module dp_sram_clr_fsm implements the clear FSM and counter, and outputs ready, clr_we and clr_addr.
REQ-034 The memory array has one write port, multiplexed between the clear FSM and the right port, and two read ports.

Verification
REQ-035 Scenario: hold rst_n=0 for 2 cycles, then release -> ready=0 for 17 cycles (IDLE plus 16 CLEAR), ready=1 in the 18th cycle, and reads of all 16 addresses return 0x00.
REQ-036 Scenario: write 0xA5 to address 3, then read address 3 on both ports in the next cycle -> one cycle later data_out_r=data_out_l=0xA5 and valid_r=valid_l=1.
REQ-037 Scenario: memory[7]=0x11; in the same cycle write 0x22 to address 7 and read left address 7 -> collision=1, and data_out_l=0x22 if DP_SRAM_BYPASS_EN is defined, else 0x11.
REQ-038 Scenario: with ce_l_n=1, drive address_l=5 -> valid_l stays 0 and data_out_l is unchanged.
REQ-039 Scenario: assert rst_n=0 during CLEAR at cnt=9 -> after release, ready rises DEPTH+1 cycles later and every address reads 0.
REQ-040 Scenario: with ready=0, request a right write of 0xFF to address 2 -> the write is ignored and address 2 reads 0x00 after ready.
